// File: rtl/hilo_mdu_ctrl.sv
// rtl/hilo_mdu_ctrl.sv - EX-stage multiply/divide sequencer with the architectural HI/LO pair
module hilo_mdu_ctrl #(
    parameter int Data_Bus = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [Data_Bus-1:0] src1,
    input  logic [Data_Bus-1:0] src2,
    input  logic                flush,
    output logic                stall_o,
    output logic                busy,
    output logic                done,
    output logic [Data_Bus-1:0] hi_o,
    output logic [Data_Bus-1:0] lo_o
);

    localparam int CW = $clog2((DIV_ITER > MUL_LAT) ? DIV_ITER : MUL_LAT) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         counter;
    logic [Data_Bus-1:0]   op_a;
    logic [Data_Bus-1:0]   op_b;
    logic                  is_signed;
    logic [Data_Bus-1:0]   rem_q;
    logic [Data_Bus-1:0]   quo_q;
    logic [Data_Bus-1:0]   dvs_q;

    logic                  accept_mul;
    logic                  accept_div;
    logic                  div_signed_in;
    logic [Data_Bus-1:0]   mag1;
    logic [Data_Bus-1:0]   mag2;
    logic [2*Data_Bus-1:0] ext_a;
    logic [2*Data_Bus-1:0] ext_b;
    logic [2*Data_Bus-1:0] prod;
    logic [Data_Bus:0]     trial;
    logic                  take;
    logic [Data_Bus-1:0]   rem_nx;
    logic [Data_Bus-1:0]   quo_nx;
    logic [Data_Bus-1:0]   quo_fix;
    logic [Data_Bus-1:0]   rem_fix;

    assign accept_mul    = (state == IDLE) && start && !flush && (op == 3'd0 || op == 3'd1);
    assign accept_div    = (state == IDLE) && start && !flush && (op == 3'd2 || op == 3'd3);
    assign stall_o       = accept_mul || accept_div || (state == MUL) || (state == DIV);

    assign div_signed_in = (op == 3'd2);
    assign mag1 = (div_signed_in && src1[Data_Bus-1]) ? -src1 : src1;
    assign mag2 = (div_signed_in && src2[Data_Bus-1]) ? -src2 : src2;

    // Sign-extending to full width makes one unsigned multiply serve both MULT and MULTU.
    assign ext_a = {{Data_Bus{is_signed & op_a[Data_Bus-1]}}, op_a};
    assign ext_b = {{Data_Bus{is_signed & op_b[Data_Bus-1]}}, op_b};
    assign prod  = ext_a * ext_b;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign trial  = {rem_q, quo_q[Data_Bus-1]};
    assign take   = trial >= {1'b0, dvs_q};
    assign rem_nx = take ? Data_Bus'(trial - {1'b0, dvs_q}) : trial[Data_Bus-1:0];
    assign quo_nx = {quo_q[Data_Bus-2:0], take};

    assign quo_fix = (is_signed && (op_a[Data_Bus-1] ^ op_b[Data_Bus-1])) ? -quo_nx : quo_nx;
    assign rem_fix = (is_signed && op_a[Data_Bus-1]) ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi_o      <= '0;
            lo_o      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            is_signed <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_mul) begin
                        state     <= MUL;
                        busy      <= 1'b1;
                        counter   <= CW'(MUL_LAT - 1);
                        op_a      <= src1;
                        op_b      <= src2;
                        is_signed <= (op == 3'd0);
                    end else if (accept_div) begin
                        state     <= DIV;
                        busy      <= 1'b1;
                        counter   <= CW'(DIV_ITER - 1);
                        op_a      <= src1;
                        op_b      <= src2;
                        is_signed <= div_signed_in;
                        rem_q     <= '0;
                        quo_q     <= mag1;
                        dvs_q     <= mag2;
                    end else if (start && !flush && op == 3'd4) begin
                        hi_o <= src1;
                    end else if (start && !flush && op == 3'd5) begin
                        lo_o <= src1;
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (counter == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        {hi_o, lo_o} <= prod;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem_q   <= rem_nx;
                        quo_q   <= quo_nx;
                        counter <= counter - 1'b1;
                        if (counter == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            counter <= '0;
                            // Divide by zero still runs every iteration; only the result is overridden.
                            if (op_b == '0) begin
                                lo_o <= '1;
                                hi_o <= op_a;
                            end else begin
                                lo_o <= quo_fix;
                                hi_o <= rem_fix;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
